// File: rtl/ef_apb_master.sv
// rtl/ef_apb_master.sv - APB3 initiator turning a command port into write, read and poll transfers
module ef_apb_master #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int TIMEOUT  = 255,
  parameter int POLL_GAP = 4,
  parameter int POLL_MAX = 1024
) (
  input  logic          PCLK,
  input  logic          PRESET,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  input  logic [DW-1:0] cmd_mask,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] PADDR,
  output logic          PSEL,
  output logic          PENABLE,
  output logic          PWRITE,
  output logic [DW-1:0] PWDATA,
  input  logic [DW-1:0] PRDATA,
  input  logic          PREADY,
  input  logic          PSLVERR
);

  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam int PCW = $clog2(POLL_MAX + 1);
  localparam int GCW = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;

  localparam logic [1:0] OP_WR   = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_POLL = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_GAP,
    S_RESP
  } state_t;

  state_t state, state_nx;

  logic [1:0]     op_q;
  logic [AW-1:0]  addr_q;
  logic [DW-1:0]  wdata_q;
  logic [DW-1:0]  mask_q;
  logic [DW-1:0]  rdata_q;
  logic           err_q;
  logic [WCW-1:0] wait_cnt;
  logic [PCW-1:0] poll_cnt;
  logic [GCW-1:0] gap_cnt;

  logic accept;
  logic timeout_hit;
  logic poll_hit;
  logic poll_last;
  logic gap_done;

  assign accept      = (state == S_IDLE) && cmd_valid;
  // The wait counter holds the number of ACCESS cycles already spent with PREADY low
  assign timeout_hit = (wait_cnt == WCW'(TIMEOUT - 1));
  assign poll_hit    = ((PRDATA & mask_q) != '0);
  // True when the read now completing is the last one the poll is allowed
  assign poll_last   = (poll_cnt == PCW'(POLL_MAX - 1));
  assign gap_done    = (gap_cnt == GCW'(POLL_GAP - 1));

  // State register; asynchronous reset drops the bus immediately
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (accept) state_nx = (cmd_op == OP_RSVD) ? S_RESP : S_SETUP;
      S_SETUP:  state_nx = S_ACCESS;
      S_ACCESS: begin
        if (PREADY) begin
          if (op_q != OP_POLL || PSLVERR || poll_hit || poll_last) state_nx = S_RESP;
          else if (POLL_GAP == 0)                                  state_nx = S_SETUP;
          else                                                     state_nx = S_GAP;
        end else if (timeout_hit) begin
          state_nx = S_RESP;
        end
      end
      S_GAP:    if (gap_done) state_nx = S_SETUP;
      S_RESP:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Outputs decoded from state; address/data come straight from the command registers
  always_comb begin
    cmd_ready = (state == S_IDLE);
    PSEL      = (state == S_SETUP) || (state == S_ACCESS);
    PENABLE   = (state == S_ACCESS);
    PWRITE    = PSEL && (op_q == OP_WR);
    PADDR     = addr_q;
    PWDATA    = wdata_q;
    rsp_valid = (state == S_RESP);
    rsp_rdata = (state == S_RESP) ? rdata_q : '0;
    rsp_err   = (state == S_RESP) && err_q;
  end

  // Command capture, response capture and the wait/poll/gap counters
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      op_q     <= OP_WR;
      addr_q   <= '0;
      wdata_q  <= '0;
      mask_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      wait_cnt <= '0;
      poll_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q     <= cmd_op;
            addr_q   <= cmd_addr;
            wdata_q  <= (cmd_op == OP_WR) ? cmd_wdata : '0;
            mask_q   <= cmd_mask;
            rdata_q  <= '0;
            err_q    <= (cmd_op == OP_RSVD);
            poll_cnt <= '0;
          end
        end
        S_ACCESS: begin
          gap_cnt <= '0;
          if (PREADY) begin
            // Read data is dropped on error, but a poll keeps whatever it last saw
            if (op_q == OP_POLL)             rdata_q <= PRDATA;
            else if (op_q == OP_RD && !PSLVERR) rdata_q <= PRDATA;
            else                             rdata_q <= '0;
            err_q <= PSLVERR || (op_q == OP_POLL && !poll_hit && poll_last);
            if (op_q == OP_POLL) poll_cnt <= poll_cnt + 1'b1;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_GAP:   gap_cnt <= gap_cnt + 1'b1;
        default: ;
      endcase
      if (state_nx == S_SETUP && state != S_SETUP) wait_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_ef_apb_master.sv
// tb/tb_ef_apb_master.sv - randomized and directed bench for ef_apb_master with a transfer-level model
module tb_ef_apb_master;

  localparam int T_A = 255, G_A = 4, M_A = 1024;
  localparam int T_B = 8,   G_B = 0, M_B = 3;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid_a, cmd_valid_b;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr, cmd_wdata, cmd_mask;
  logic        PREADY, PSLVERR;
  logic [31:0] PRDATA;

  logic        cmd_ready_a, rsp_valid_a, rsp_err_a, psel_a, penable_a, pwrite_a;
  logic [31:0] rsp_rdata_a, paddr_a, pwdata_a;
  logic        cmd_ready_b, rsp_valid_b, rsp_err_b, psel_b, penable_b, pwrite_b;
  logic [31:0] rsp_rdata_b, paddr_b, pwdata_b;

  int n_vec = 0;
  int n_bad = 0;

  ef_apb_master #(.AW(32), .DW(32), .TIMEOUT(T_A), .POLL_GAP(G_A), .POLL_MAX(M_A)) dut_a (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a),
    .PADDR(paddr_a), .PSEL(psel_a), .PENABLE(penable_a), .PWRITE(pwrite_a), .PWDATA(pwdata_a),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  ef_apb_master #(.AW(32), .DW(32), .TIMEOUT(T_B), .POLL_GAP(G_B), .POLL_MAX(M_B)) dut_b (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
    .PADDR(paddr_b), .PSEL(psel_b), .PENABLE(penable_b), .PWRITE(pwrite_b), .PWDATA(pwdata_b),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // Shared APB bus view; only one initiator is ever busy at a time
  logic        psel, penable, pwrite_m;
  logic [31:0] paddr_m, pwdata_m;
  assign psel     = psel_a | psel_b;
  assign penable  = penable_a | penable_b;
  assign pwrite_m = psel_b ? pwrite_b : pwrite_a;
  assign paddr_m  = psel_b ? paddr_b  : paddr_a;
  assign pwdata_m = psel_b ? pwdata_b : pwdata_a;

  // Per-transfer responder script: wait states, read data, slave error
  int          wait_tab [2048];
  logic [31:0] data_tab [2048];
  bit          slv_tab  [2048];
  int          xi = 0, cur = 0, acc_n = 0;
  int          n_setup = 0, n_acc = 0, n_rsp = 0, field_bad = 0;
  logic [31:0] exp_addr = '0, exp_pwdata = '0;
  logic        exp_pwrite = 1'b0;

  // Scripted slave plus bus observer; PSLVERR is forced high during wait states
  always @(negedge PCLK) begin
    if (rsp_valid_a || rsp_valid_b) n_rsp++;
    if (psel && (paddr_m !== exp_addr || pwrite_m !== exp_pwrite || pwdata_m !== exp_pwdata))
      field_bad++;
    if (psel && !penable) begin
      cur = xi; xi++; acc_n = 0; n_setup++;
      PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
    end else if (psel && penable) begin
      acc_n++; n_acc++;
      if (acc_n > wait_tab[cur & 2047]) begin
        PREADY = 1'b1; PRDATA = data_tab[cur & 2047]; PSLVERR = slv_tab[cur & 2047];
      end else begin
        PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'b1;
      end
    end else begin
      PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
    end
  end

  task automatic set_xfer(input int k, input int w, input logic [31:0] d, input bit s);
    wait_tab[(xi + k) & 2047] = w;
    data_tab[(xi + k) & 2047] = d;
    slv_tab[(xi + k) & 2047]  = s;
  endtask

  // Transfer-level reference: cycles from accept to rsp_valid, outcome and number of APB transfers
  function automatic void model(input bit b, input logic [1:0] op, input logic [31:0] mask,
                                input int base, output int lat, output logic err,
                                output logic [31:0] rdata, output int setups);
    int t, g, pm, w, reads;
    logic [31:0] d;
    bit s, done;
    t = b ? T_B : T_A; g = b ? G_B : G_A; pm = b ? M_B : M_A;
    lat = 0; err = 1'b0; rdata = '0; setups = 0; reads = 0; done = 1'b0;
    if (op == 2'b11) begin
      lat = 1; err = 1'b1;
    end else begin
      for (int it = 0; it < 2048 && !done; it++) begin
        w = wait_tab[(base + setups) & 2047];
        d = data_tab[(base + setups) & 2047];
        s = slv_tab[(base + setups) & 2047];
        setups++;
        if (w >= t) begin
          lat += 1 + t; err = 1'b1; rdata = '0; done = 1'b1;
        end else begin
          lat += 2 + w;
          if (op != 2'b10) begin
            err = s; rdata = (op == 2'b01 && !s) ? d : '0; done = 1'b1;
          end else begin
            reads++;
            if (s || (d & mask) != 0) begin err = s; rdata = d; done = 1'b1; end
            else if (reads == pm)     begin err = 1'b1; rdata = d; done = 1'b1; end
            else lat += g;
          end
        end
      end
      lat += 1;
    end
  endfunction

  // Issue one command from a falling edge with the target idle; returns at a falling edge, idle again
  task automatic run_cmd(input bit b, input logic [1:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] mask,
                         output int lat, output logic err, output logic [31:0] rdata,
                         output int setups, output int accs, output int fbad, output int busy,
                         output bit to, output bit after_ok);
    int s0, a0, f0;
    cmd_op = op; cmd_addr = addr; cmd_wdata = wdata; cmd_mask = mask;
    exp_addr = addr; exp_pwrite = (op == 2'b00); exp_pwdata = (op == 2'b00) ? wdata : '0;
    s0 = n_setup; a0 = n_acc; f0 = field_bad;
    busy = 0; to = 1'b1; lat = 0; err = 1'bx; rdata = 'x;
    if (b) cmd_valid_b = 1'b1; else cmd_valid_a = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid_a = 1'b0; cmd_valid_b = 1'b0;
    cmd_op = 2'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom; cmd_mask = $urandom;
    for (int i = 0; i < 6000; i++) begin
      lat++;
      if (b ? rsp_valid_b : rsp_valid_a) begin
        err = b ? rsp_err_b : rsp_err_a; rdata = b ? rsp_rdata_b : rsp_rdata_a; to = 1'b0;
        break;
      end
      if (b ? cmd_ready_b : cmd_ready_a) busy++;
      @(negedge PCLK);
    end
    setups = n_setup - s0; accs = n_acc - a0; fbad = field_bad - f0;
    @(negedge PCLK);
    after_ok = b ? (!rsp_valid_b && cmd_ready_b) : (!rsp_valid_a && cmd_ready_a);
  endtask

  int lat, setups, accs, fbad, busy;
  logic err;
  logic [31:0] rdata;
  bit to, after_ok;

  task automatic test_reset();
    PRESET = 1'b1; cmd_valid_a = 1'b0; cmd_valid_b = 1'b0;
    cmd_op = '0; cmd_addr = '0; cmd_wdata = '0; cmd_mask = '0;
    repeat (3) @(negedge PCLK);
    n_vec++; if ({cmd_ready_a, psel_a, penable_a, pwrite_a, rsp_valid_a, rsp_err_a} !== 6'b100000) begin
      n_bad++; $display("FAIL reset_ctrl got %b want 100000", {cmd_ready_a, psel_a, penable_a, pwrite_a, rsp_valid_a, rsp_err_a}); end
    n_vec++; if ((paddr_a | pwdata_a | rsp_rdata_a) !== 32'h0) begin
      n_bad++; $display("FAIL reset_data got %h/%h/%h want 0", paddr_a, pwdata_a, rsp_rdata_a); end
    PRESET = 1'b0;
    @(negedge PCLK);
    n_vec++; if ({cmd_ready_a, cmd_ready_b, psel} !== 3'b110) begin
      n_bad++; $display("FAIL reset_release got %b want 110", {cmd_ready_a, cmd_ready_b, psel}); end
  endtask

  task automatic test_write();
    set_xfer(0, 0, $urandom, 1'b0);
    run_cmd(1'b0, 2'b00, 32'h10, 32'hA5, 32'h0, lat, err, rdata, setups, accs, fbad, busy, to, after_ok);
    n_vec++; if (lat !== 3 || to) begin n_bad++; $display("FAIL wr_latency got %0d want 3", lat); end
    n_vec++; if ({err, rdata} !== 33'h0) begin n_bad++; $display("FAIL wr_rsp got err=%b rdata=%h want 0/0", err, rdata); end
    n_vec++; if (setups !== 1 || accs !== 1 || fbad !== 0) begin
      n_bad++; $display("FAIL wr_bus got setups=%0d accs=%0d fbad=%0d want 1/1/0", setups, accs, fbad); end
    n_vec++; if (busy !== 0 || !after_ok) begin n_bad++; $display("FAIL wr_handshake got busy=%0d after=%b want 0/1", busy, after_ok); end
  endtask

  task automatic test_read_wait();
    set_xfer(0, 3, 32'h1234, 1'b0);
    run_cmd(1'b0, 2'b01, 32'h0C, 32'hDEAD, 32'h0, lat, err, rdata, setups, accs, fbad, busy, to, after_ok);
    n_vec++; if (lat !== 6 || accs !== 4) begin n_bad++; $display("FAIL rd_wait got lat=%0d accs=%0d want 6/4", lat, accs); end
    n_vec++; if (err !== 1'b0 || rdata !== 32'h1234 || fbad !== 0) begin
      n_bad++; $display("FAIL rd_rsp got err=%b rdata=%h fbad=%0d want 0/1234/0", err, rdata, fbad); end
  endtask

  task automatic test_poll();
    set_xfer(0, 0, 32'h0, 1'b0); set_xfer(1, 0, 32'h0, 1'b0);
    set_xfer(2, 0, 32'h0, 1'b0); set_xfer(3, 0, 32'h4, 1'b0);
    run_cmd(1'b0, 2'b10, 32'h24, 32'h0, 32'h4, lat, err, rdata, setups, accs, fbad, busy, to, after_ok);
    n_vec++; if (setups !== 4 || accs !== 4) begin n_bad++; $display("FAIL poll_reads got setups=%0d accs=%0d want 4/4", setups, accs); end
    n_vec++; if (lat !== 21) begin n_bad++; $display("FAIL poll_gap_latency got %0d want 21", lat); end
    n_vec++; if (err !== 1'b0 || rdata !== 32'h4 || fbad !== 0) begin
      n_bad++; $display("FAIL poll_rsp got err=%b rdata=%h fbad=%0d want 0/4/0", err, rdata, fbad); end
  endtask

  task automatic test_timeout();
    set_xfer(0, 100000, 32'h5555, 1'b0);
    run_cmd(1'b0, 2'b01, 32'h30, 32'h0, 32'h0, lat, err, rdata, setups, accs, fbad, busy, to, after_ok);
    n_vec++; if (accs !== T_A || lat !== T_A + 2) begin n_bad++; $display("FAIL timeout_len got accs=%0d lat=%0d want 255/257", accs, lat); end
    n_vec++; if (err !== 1'b1 || rdata !== 32'h0) begin n_bad++; $display("FAIL timeout_rsp got err=%b rdata=%h want 1/0", err, rdata); end
    set_xfer(0, 0, 32'h0, 1'b0);
    run_cmd(1'b0, 2'b00, 32'h34, 32'h77, 32'h0, lat, err, rdata, setups, accs, fbad, busy, to, after_ok);
    n_vec++; if (lat !== 3 || err !== 1'b0 || !after_ok) begin
      n_bad++; $display("FAIL timeout_recover got lat=%0d err=%b want 3/0", lat, err); end
  endtask

  task automatic test_slverr();
    set_xfer(0, 2, 32'h0, 1'b1);
    run_cmd(1'b0, 2'b00, 32'h40, 32'h99, 32'h0, lat, err, rdata, setups, accs, fbad, busy, to, after_ok);
    n_vec++; if (err !== 1'b1 || rdata !== 32'h0 || lat !== 5) begin
      n_bad++; $display("FAIL slverr_wr got err=%b rdata=%h lat=%0d want 1/0/5", err, rdata, lat); end
    set_xfer(0, 2, 32'hCAFE, 1'b0);
    run_cmd(1'b0, 2'b01, 32'h44, 32'h0, 32'h0, lat, err, rdata, setups, accs, fbad, busy, to, after_ok);
    n_vec++; if (err !== 1'b0 || rdata !== 32'hCAFE) begin
      n_bad++; $display("FAIL slverr_ignored got err=%b rdata=%h want 0/cafe", err, rdata); end
  endtask

  task automatic test_reset_mid();
    int r0;
    set_xfer(0, 100000, 32'h0, 1'b0);
    cmd_op = 2'b01; cmd_addr = 32'h48; cmd_wdata = '0; cmd_mask = '0;
    exp_addr = 32'h48; exp_pwrite = 1'b0; exp_pwdata = '0;
    cmd_valid_a = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid_a = 1'b0;
    repeat (2) @(negedge PCLK);
    n_vec++; if (penable_a !== 1'b1) begin n_bad++; $display("FAIL rstmid_access got penable=%b want 1", penable_a); end
    r0 = n_rsp;
    PRESET = 1'b1;
    #1;
    n_vec++; if ({psel_a, penable_a} !== 2'b00) begin n_bad++; $display("FAIL rstmid_drop got %b want 00", {psel_a, penable_a}); end
    repeat (3) @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
    #1;
    n_vec++; if (n_rsp !== r0 || cmd_ready_a !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_after got rsps=%0d ready=%b want 0/1", n_rsp - r0, cmd_ready_a); end
    @(negedge PCLK);
  endtask

  task automatic test_poll_max();
    set_xfer(0, 0, 32'h0, 1'b0); set_xfer(1, 0, 32'h0, 1'b0);
    set_xfer(2, 0, 32'h0, 1'b0); set_xfer(3, 0, 32'hFFFFFFFF, 1'b0);
    run_cmd(1'b1, 2'b10, 32'h50, 32'h0, 32'hFFFFFFFF, lat, err, rdata, setups, accs, fbad, busy, to, after_ok);
    n_vec++; if (setups !== 3 || lat !== 7) begin n_bad++; $display("FAIL pollmax_reads got setups=%0d lat=%0d want 3/7", setups, lat); end
    n_vec++; if (err !== 1'b1 || rdata !== 32'h0) begin n_bad++; $display("FAIL pollmax_rsp got err=%b rdata=%h want 1/0", err, rdata); end
  endtask

  task automatic test_reserved();
    run_cmd(1'b0, 2'b11, 32'h60, 32'h1, 32'h1, lat, err, rdata, setups, accs, fbad, busy, to, after_ok);
    n_vec++; if (lat !== 1 || setups !== 0) begin n_bad++; $display("FAIL rsvd_bus got lat=%0d setups=%0d want 1/0", lat, setups); end
    n_vec++; if (err !== 1'b1 || rdata !== 32'h0 || !after_ok) begin
      n_bad++; $display("FAIL rsvd_rsp got err=%b rdata=%h want 1/0", err, rdata); end
  endtask

  task automatic test_back_to_back();
    int acc_cyc[$];
    int s0, r0;
    set_xfer(0, 0, 32'h0, 1'b0); set_xfer(1, 0, 32'h0, 1'b0);
    cmd_op = 2'b00; cmd_addr = 32'h70; cmd_wdata = 32'h1357; cmd_mask = '0;
    exp_addr = 32'h70; exp_pwrite = 1'b1; exp_pwdata = 32'h1357;
    s0 = n_setup; r0 = n_rsp;
    cmd_valid_a = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (cmd_ready_a) acc_cyc.push_back(i);
      @(negedge PCLK);
      if (acc_cyc.size() == 2) break;
    end
    cmd_valid_a = 1'b0;
    repeat (4) @(negedge PCLK);
    #1;
    n_vec++; if (acc_cyc.size() !== 2 || acc_cyc[1] - acc_cyc[0] !== 4) begin
      n_bad++; $display("FAIL b2b_spacing got n=%0d gap=%0d want 2/4", acc_cyc.size(),
                        (acc_cyc.size() == 2) ? acc_cyc[1] - acc_cyc[0] : -1); end
    n_vec++; if (n_setup - s0 !== 2 || n_rsp - r0 !== 2) begin
      n_bad++; $display("FAIL b2b_count got setups=%0d rsps=%0d want 2/2", n_setup - s0, n_rsp - r0); end
  endtask

  task automatic test_random();
    int e_lat, e_setups, base, w, sel;
    logic e_err;
    logic [31:0] e_rdata, mask, d;
    logic [1:0] op;
    bit b;
    for (int it = 0; it < 60; it++) begin
      b = 1'($urandom);
      sel = $urandom_range(0, 9);
      op = (sel < 3) ? 2'b00 : (sel < 6) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
      mask = (32'h1 << $urandom_range(0, 31)) | (($urandom_range(0, 3) == 0) ? $urandom : 32'h0);
      for (int k = 0; k < 8; k++) begin
        if (b) begin
          sel = $urandom_range(0, 5);
          w = (sel < 4) ? sel : (sel == 4) ? T_B - 1 : T_B;
        end else w = $urandom_range(0, 3);
        d = ($urandom_range(0, 2) == 0 || k == 5) ? ($urandom | mask) : ($urandom & ~mask);
        set_xfer(k, w, d, $urandom_range(0, 7) == 0);
      end
      base = xi;
      model(b, op, mask, base, e_lat, e_err, e_rdata, e_setups);
      run_cmd(b, op, $urandom, $urandom, mask, lat, err, rdata, setups, accs, fbad, busy, to, after_ok);
      n_vec++; if (to || lat !== e_lat) begin
        n_bad++; $display("FAIL rnd%0d_latency dut=%0d op=%0d got %0d want %0d", it, b, op, lat, e_lat); end
      n_vec++; if (err !== e_err || rdata !== e_rdata) begin
        n_bad++; $display("FAIL rnd%0d_rsp dut=%0d op=%0d got err=%b rdata=%h want err=%b rdata=%h", it, b, op, err, rdata, e_err, e_rdata); end
      n_vec++; if (setups !== e_setups || fbad !== 0) begin
        n_bad++; $display("FAIL rnd%0d_bus dut=%0d op=%0d got setups=%0d fbad=%0d want %0d/0", it, b, op, setups, fbad, e_setups); end
      n_vec++; if (busy !== 0 || !after_ok) begin
        n_bad++; $display("FAIL rnd%0d_handshake got busy=%0d after=%b want 0/1", it, busy, after_ok); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_poll();
    test_timeout();
    test_slverr();
    test_reset_mid();
    test_poll_max();
    test_reserved();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
